pkt_tx: RTL and testbench

- Per-port ingress transmitter for the 4-port switch. Accepts host send requests (target mask + payload) and buffers them in a small FIFO.
- Sanitises each target mask so it always passes the switch's source/target validity rule, classifies it SDP/MDP/BDP, and drives a valid/ready packet interface toward the switch fabric parser.
- Drops illegal requests, aborts packets the fabric never accepts (timeout), and keeps saturating statistics.

---
 rtl/switch_pkg.sv | 25 ++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/pkt_tx.sv | 228 ++++++++++++++++++++++
 tb/tb_pkt_tx.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// -----------------------------------------------------------------------------
// switch_pkg
// Definitions shared by the blocks of the 4-port switch.
//   p_type       : packet classification (single, multi, broadcast destination,
//                  or ERR for a mask that cannot be sent)
//   NUM_PORTS    : number of switch ports, which is also the width of the
//                  source and target masks
//   ERR_*        : codes reported on a transmitter's err_code output
// -----------------------------------------------------------------------------
package switch_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    SDP = 2'd0,  // single destination
    MDP = 2'd1,  // two or three destinations
    BDP = 2'd2,  // all four ports
    ERR = 2'd3   // no legal destination
  } p_type;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

endpackage : switch_pkg

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO. The head entry is presented combinationally from the
// storage array, so a consumer can look at it and pop it in the same cycle.
// A push while full or a pop while empty is ignored.
//   clk, rst_n : clock, asynchronous active-low reset (empties the FIFO)
//   push       : write data_in at the clock edge
//   data_in    : entry to write
//   pop        : drop the head entry at the clock edge
//   head       : oldest entry (meaningless while empty)
//   full       : no free entry
//   empty      : no valid entry
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;  // extra wrap bit separates full from empty

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = push_ok ? wr_q + PW'(1) : wr_q;
    rd_d = pop_ok  ? rd_q + PW'(1) : rd_q;
  end

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples the values from before the edge, whatever the order of
  // statements and blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, and leaving the array unreset lets it map to plain
  // registers or RAM.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q[AW-1:0]] <= data_in;
    end
  end

endmodule : sync_fifo

// File: rtl/pkt_tx.sv
// -----------------------------------------------------------------------------
// pkt_tx
// Per-port ingress transmitter. Host requests (target mask + payload) are
// buffered in a FIFO. Each target mask is then sanitised against this port's
// source bit, classified, and offered to the fabric parser on a valid/ready
// interface. Illegal requests are dropped. A packet the fabric does not accept
// within TIMEOUT cycles is aborted. Both cases raise a one-cycle error pulse
// and are counted.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : host request handshake (ready = FIFO not full)
//   req_target, req_data  : requested destination mask, payload
//   tx_valid/tx_ready     : packet handshake toward the fabric
//   tx_source             : constant one-hot source, 1 << PORT_ID
//   tx_target, tx_type    : sanitised mask and its classification
//   tx_data               : payload
//   err_pulse, err_code   : one-cycle drop/abort indication and its reason
//   sent_cnt, drop_cnt    : saturating statistics
// -----------------------------------------------------------------------------
module pkt_tx
  import switch_pkg::*;
#(
  parameter int PORT_ID    = 0,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16,
  parameter int CNT_W      = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [NUM_PORTS-1:0] req_target,
  input  logic [DATA_W-1:0]    req_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [NUM_PORTS-1:0] tx_source,
  output logic [NUM_PORTS-1:0] tx_target,
  output p_type                tx_type,
  output logic [DATA_W-1:0]    tx_data,
  output logic                 err_pulse,
  output logic [1:0]           err_code,
  output logic [CNT_W-1:0]     sent_cnt,
  output logic [CNT_W-1:0]     drop_cnt
);

  localparam logic [NUM_PORTS-1:0] SRC_MASK = NUM_PORTS'(1) << PORT_ID;
  localparam int                   FW       = NUM_PORTS + DATA_W;
  localparam int                   WAIT_W   = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]    WAIT_MAX = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  typedef struct packed {
    logic                 legal;
    logic [NUM_PORTS-1:0] st;
    p_type                typ;
  } san_t;

  // The fabric rejects a packet addressed back to its own source, except
  // broadcast, which may include the sender. Masks with no destination left
  // after the self bit is removed cannot be sent.
  function automatic san_t sanitise(input logic [NUM_PORTS-1:0] target);
    san_t       r;
    logic [2:0] ones;
    r.st    = (target == '1) ? target : (target & ~SRC_MASK);
    r.legal = |r.st;
    ones    = 3'($countones(r.st));
    case (ones)
      3'd1:       r.typ = SDP;
      3'd2, 3'd3: r.typ = MDP;
      3'd4:       r.typ = BDP;
      default:    r.typ = ERR;
    endcase
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [FW-1:0]        fifo_head;
  logic [NUM_PORTS-1:0] head_target;
  logic [DATA_W-1:0]    head_data;
  san_t                 head_san;

  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && !fifo_full;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (fifo_push),
    .data_in ({req_target, req_data}),
    .pop     (fifo_pop),
    .head    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign head_target = fifo_head[FW-1 -: NUM_PORTS];
  assign head_data   = fifo_head[DATA_W-1:0];
  assign head_san    = sanitise(head_target);

  // ---------------------------------------------------------------------------
  // Transmit FSM: next-state and registered-output logic
  // ---------------------------------------------------------------------------
  state_e               state_q,     state_d;
  logic                 tx_valid_q,  tx_valid_d;
  logic [NUM_PORTS-1:0] tgt_q,       tgt_d;
  p_type                type_q,      type_d;
  logic [DATA_W-1:0]    data_q,      data_d;
  logic [WAIT_W-1:0]    wait_q,      wait_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [1:0]           err_code_q,  err_code_d;
  logic [CNT_W-1:0]     sent_q,      sent_d;
  logic [CNT_W-1:0]     drop_q,      drop_d;
  logic                 load_head;
  logic                 sent_inc;
  logic                 drop_inc;

  // NOTE: every variable assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tgt_d       = tgt_q;
    type_d      = type_q;
    data_d      = data_q;
    wait_d      = wait_q;
    err_pulse_d = 1'b0;
    err_code_d  = ERR_NONE;
    fifo_pop    = 1'b0;
    load_head   = 1'b0;
    sent_inc    = 1'b0;
    drop_inc    = 1'b0;

    // Both states pull the next head the same way; SEND only does so once
    // the current packet has been handed over.
    unique case (state_q)
      S_IDLE: begin
        fifo_pop = !fifo_empty;
      end
      S_SEND: begin
        if (tx_ready) begin
          // A ready in the final wait cycle still counts as a send.
          sent_inc = 1'b1;
          state_d  = S_IDLE;
          fifo_pop = !fifo_empty;
        end else if (wait_q == WAIT_MAX) begin
          state_d     = S_IDLE;
          err_pulse_d = 1'b1;
          err_code_d  = ERR_TIMEOUT;
          drop_inc    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (fifo_pop) begin
      if (head_san.legal) begin
        load_head = 1'b1;
      end else begin
        err_pulse_d = 1'b1;
        err_code_d  = ERR_ILLEGAL;
        drop_inc    = 1'b1;
      end
    end

    if (load_head) begin
      state_d = S_SEND;
      tgt_d   = head_san.st;
      type_d  = head_san.typ;
      data_d  = head_data;
      wait_d  = '0;
    end

    tx_valid_d = (state_d == S_SEND);
    sent_d     = (sent_inc && sent_q != '1) ? sent_q + CNT_W'(1) : sent_q;
    drop_d     = (drop_inc && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tx_valid_q  <= 1'b0;
      tgt_q       <= '0;
      type_q      <= ERR;
      data_q      <= '0;
      wait_q      <= '0;
      err_pulse_q <= 1'b0;
      err_code_q  <= ERR_NONE;
      sent_q      <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      tx_valid_q  <= tx_valid_d;
      tgt_q       <= tgt_d;
      type_q      <= type_d;
      data_q      <= data_d;
      wait_q      <= wait_d;
      err_pulse_q <= err_pulse_d;
      err_code_q  <= err_code_d;
      sent_q      <= sent_d;
      drop_q      <= drop_d;
    end
  end

  assign tx_source = SRC_MASK;
  assign tx_valid  = tx_valid_q;
  assign tx_target = tgt_q;
  assign tx_type   = type_q;
  assign tx_data   = data_q;
  assign err_pulse = err_pulse_q;
  assign err_code  = err_code_q;
  assign sent_cnt  = sent_q;
  assign drop_cnt  = drop_q;

endmodule : pkt_tx

// File: tb/tb_pkt_tx.sv
// -----------------------------------------------------------------------------
// tb_pkt_tx
// Directed and randomized checks of pkt_tx with PORT_ID=0 and TIMEOUT=16.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled at
// that point too, or on the falling edge.
// -----------------------------------------------------------------------------
module tb_pkt_tx;
  import switch_pkg::*;

  localparam int DATA_W  = 8;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [3:0]        req_target = '0;
  logic [DATA_W-1:0] req_data = '0;
  logic              tx_valid;
  logic              tx_ready = 1'b0;
  logic [3:0]        tx_source;
  logic [3:0]        tx_target;
  p_type             tx_type;
  logic [DATA_W-1:0] tx_data;
  logic              err_pulse;
  logic [1:0]        err_code;
  logic [CNT_W-1:0]  sent_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  pkt_tx #(
    .PORT_ID    (0),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_target (req_target),
    .req_data   (req_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .tx_source  (tx_source),
    .tx_target  (tx_target),
    .tx_type    (tx_type),
    .tx_data    (tx_data),
    .err_pulse  (err_pulse),
    .err_code   (err_code),
    .sent_cnt   (sent_cnt),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Outcome the reference model predicts for one accepted request.
  typedef struct packed {
    logic              legal;
    logic [3:0]        st;
    p_type             typ;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   exp_sent;
  int   exp_drop;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    rst_n     = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push(input logic [3:0] tgt, input logic [DATA_W-1:0] d);
    req_valid  = 1'b1;
    req_target = tgt;
    req_data   = d;
    tick();
    req_valid = 1'b0;
  endtask

  // Model for port 0. A mask that names every port is sent unchanged. Any
  // other mask loses bit 0. An empty result is dropped. The type comes from
  // the number of destinations left.
  function automatic exp_t model_of(input logic [3:0] tgt, input logic [DATA_W-1:0] d);
    exp_t e;
    int   n;
    e.st    = (tgt == 4'b1111) ? tgt : {tgt[3:1], 1'b0};
    n       = $countones(e.st);
    e.legal = (n != 0);
    e.typ   = (n == 0) ? ERR : (n == 1) ? SDP : (n == 4) ? BDP : MDP;
    e.data  = d;
    return e;
  endfunction

  // Single-packet send with tx_ready held high: two-cycle latency, one
  // cycle of tx_valid.
  task automatic send_one(input string tag, input logic [3:0] tgt, input logic [DATA_W-1:0] d,
                          input logic [3:0] exp_tgt, input p_type exp_typ);
    push(tgt, d);
    check({tag, "_not_yet"}, 32'(tx_valid), 32'(0));
    tick();
    check({tag, "_valid"},  32'(tx_valid),  32'(1));
    check({tag, "_source"}, 32'(tx_source), 32'(4'b0001));
    check({tag, "_target"}, 32'(tx_target), 32'(exp_tgt));
    check({tag, "_type"},   32'(tx_type),   32'(exp_typ));
    check({tag, "_data"},   32'(tx_data),   32'(d));
    tick();
    check({tag, "_done"},   32'(tx_valid),  32'(0));
  endtask

  // Compares what the DUT shows on the falling edge against the head of the
  // expected-outcome queue.
  task automatic monitor();
    exp_t e;
    if (err_pulse) begin
      check("rand_err_code", 32'(err_code), 32'(ERR_ILLEGAL));
      check("rand_err_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rand_err_was_illegal", 32'(e.legal), 32'(0));
      end
    end else begin
      check("rand_err_code_idle", 32'(err_code), 32'(ERR_NONE));
    end
    if (tx_valid && tx_ready) begin
      check("rand_pkt_expected", 32'(exp_q.size() != 0), 32'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("rand_pkt_legal",  32'(e.legal),   32'(1));
        check("rand_pkt_target", 32'(tx_target), 32'(e.st));
        check("rand_pkt_type",   32'(tx_type),   32'(e.typ));
        check("rand_pkt_data",   32'(tx_data),   32'(e.data));
      end
    end
  endtask

  logic [3:0]        fill_tgt [5];
  p_type             fill_typ [5];
  exp_t              e_new;
  int                zero_run;
  int                budget;

  initial begin
    fill_tgt = '{4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1110};
    fill_typ = '{SDP, SDP, SDP, MDP, MDP};

    // ---- reset state ----
    do_reset();
    check("rst_tx_valid",  32'(tx_valid),  32'(0));
    check("rst_tx_target", 32'(tx_target), 32'(0));
    check("rst_tx_data",   32'(tx_data),   32'(0));
    check("rst_tx_type",   32'(tx_type),   32'(ERR));
    check("rst_tx_source", 32'(tx_source), 32'(4'b0001));
    check("rst_err_pulse", 32'(err_pulse), 32'(0));
    check("rst_err_code",  32'(err_code),  32'(0));
    check("rst_sent_cnt",  32'(sent_cnt),  32'(0));
    check("rst_drop_cnt",  32'(drop_cnt),  32'(0));
    check("rst_req_ready", 32'(req_ready), 32'(1));

    // ---- legal sends with the fabric always ready ----
    tx_ready = 1'b1;
    send_one("sdp", 4'b0100, 8'hA5, 4'b0100, SDP);
    check("sdp_sent_cnt", 32'(sent_cnt), 32'(1));
    send_one("mdp", 4'b0111, 8'h3C, 4'b0110, MDP);
    send_one("bdp", 4'b1111, 8'h5A, 4'b1111, BDP);
    check("bdp_sent_cnt", 32'(sent_cnt), 32'(3));

    // ---- illegal targets: self only, then no destination ----
    push(4'b0001, 8'h01);
    check("ill1_no_valid", 32'(tx_valid), 32'(0));
    tick();
    check("ill1_pulse", 32'(err_pulse), 32'(1));
    check("ill1_code",  32'(err_code),  32'(ERR_ILLEGAL));
    check("ill1_no_valid2", 32'(tx_valid), 32'(0));
    push(4'b0000, 8'h02);
    check("ill_gap_pulse", 32'(err_pulse), 32'(0));
    tick();
    check("ill2_pulse", 32'(err_pulse), 32'(1));
    check("ill2_code",  32'(err_code),  32'(ERR_ILLEGAL));
    check("ill2_no_valid", 32'(tx_valid), 32'(0));
    tick();
    check("ill_end_pulse", 32'(err_pulse), 32'(0));
    check("ill_end_code",  32'(err_code),  32'(ERR_NONE));
    check("ill_drop_cnt",  32'(drop_cnt),  32'(2));
    check("ill_sent_cnt",  32'(sent_cnt),  32'(3));

    // ---- timeout: TIMEOUT cycles of valid, then abort ----
    do_reset();
    tx_ready = 1'b0;
    push(4'b0010, 8'h11);
    tick();
    for (int i = 1; i <= TIMEOUT; i++) begin
      check("to_valid_held", 32'(tx_valid),  32'(1));
      check("to_no_pulse",   32'(err_pulse), 32'(0));
      tick();
    end
    check("to_valid_drop", 32'(tx_valid),  32'(0));
    check("to_pulse",      32'(err_pulse), 32'(1));
    check("to_code",       32'(err_code),  32'(ERR_TIMEOUT));
    check("to_drop_cnt",   32'(drop_cnt),  32'(1));
    check("to_sent_cnt",   32'(sent_cnt),  32'(0));
    tick();
    check("to_pulse_end",  32'(err_pulse), 32'(0));
    check("to_code_end",   32'(err_code),  32'(ERR_NONE));
    for (int i = 0; i < 3; i++) tick();

    // ---- ready in the last allowed cycle wins over the abort ----
    push(4'b0100, 8'h22);
    tick();
    for (int i = 1; i < TIMEOUT; i++) begin
      check("late_valid_held", 32'(tx_valid), 32'(1));
      tick();
    end
    tx_ready = 1'b1;
    check("late_valid_last", 32'(tx_valid), 32'(1));
    check("late_data",       32'(tx_data),  32'(8'h22));
    tick();
    tx_ready = 1'b0;
    check("late_valid_end", 32'(tx_valid),  32'(0));
    check("late_no_pulse",  32'(err_pulse), 32'(0));
    check("late_sent_cnt",  32'(sent_cnt),  32'(1));
    check("late_drop_cnt",  32'(drop_cnt),  32'(1));

    // ---- fill: the first request moves into the output stage, the FIFO
    //      then holds four more before req_ready drops ----
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_target = fill_tgt[i];
      req_data   = 8'h10 + 8'(i);
      check("fill_req_ready", 32'(req_ready), 32'(1));
      tick();
    end
    check("full_req_ready", 32'(req_ready), 32'(0));
    req_target = 4'b0010;
    req_data   = 8'hEE;
    tick();
    req_valid = 1'b0;
    check("full_req_ready2", 32'(req_ready), 32'(0));
    tx_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("b2b_valid",  32'(tx_valid),  32'(1));
      check("b2b_target", 32'(tx_target), 32'(fill_tgt[i]));
      check("b2b_type",   32'(tx_type),   32'(fill_typ[i]));
      check("b2b_data",   32'(tx_data),   32'(8'h10 + 8'(i)));
      tick();
    end
    check("b2b_done",      32'(tx_valid),  32'(0));
    check("b2b_sent_cnt",  32'(sent_cnt),  32'(6));
    check("b2b_req_ready", 32'(req_ready), 32'(1));

    // ---- reset in the middle of a send ----
    tx_ready = 1'b0;
    push(4'b0010, 8'h33);
    push(4'b0100, 8'h44);
    check("mid_valid_before", 32'(tx_valid), 32'(1));
    rst_n = 1'b0;
    #1;
    check("mid_valid_rst",  32'(tx_valid),  32'(0));
    check("mid_sent_rst",   32'(sent_cnt),  32'(0));
    check("mid_drop_rst",   32'(drop_cnt),  32'(0));
    check("mid_ready_rst",  32'(req_ready), 32'(1));
    tick();
    rst_n    = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("mid_fifo_gone", 32'(tx_valid), 32'(0));
    end
    check("mid_sent_after", 32'(sent_cnt), 32'(0));

    // ---- randomized traffic against the reference model ----
    do_reset();
    exp_q.delete();
    exp_sent = 0;
    exp_drop = 0;
    zero_run = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (req_ready && $urandom_range(0, 1) == 1) begin
        req_valid  = 1'b1;
        req_target = 4'($urandom_range(0, 15));
        req_data   = 8'($urandom);
        e_new      = model_of(req_target, req_data);
        exp_q.push_back(e_new);
        if (e_new.legal) exp_sent++;
        else             exp_drop++;
      end else begin
        req_valid = 1'b0;
      end
      // Stalls stay well below TIMEOUT so every legal packet is sent.
      if (zero_run >= 8) tx_ready = 1'b1;
      else               tx_ready = ($urandom_range(0, 3) != 0);
      zero_run = tx_ready ? 0 : zero_run + 1;
      @(negedge clk);
      monitor();
      tick();
    end
    req_valid = 1'b0;
    tx_ready  = 1'b1;
    budget    = 0;
    while ((exp_q.size() != 0 || tx_valid) && budget < 100) begin
      @(negedge clk);
      monitor();
      tick();
      budget++;
    end
    check("rand_drained",  32'(exp_q.size()), 32'(0));
    check("rand_sent_cnt", 32'(sent_cnt),     32'(exp_sent));
    check("rand_drop_cnt", 32'(drop_cnt),     32'(exp_drop));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_pkt_tx
